// File: rtl/fma_normalize_iter.sv
// Iterative post-normalizer feeding the FMA rounder.
// Right shift on carry-out, bounded left shifts otherwise.
module fma_normalize_iter #(
  parameter int STEP = 16,
  parameter int EMAX = 2047
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [105:0] sum_in,
  input  logic [12:0]  exp_in,
  input  logic         sticky_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [53:0]  v_out,
  output logic [12:0]  exp_out,
  output logic         zero_out,
  output logic         denorm_out,
  output logic         overflow_out
);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    SHIFT,
    DONE
  } state_t;

  localparam logic signed [12:0] EMAX_S = 13'(EMAX);
  localparam logic signed [12:0] STEP_S = 13'(STEP);

  state_t r_state;
  state_t w_state_nxt;

  logic [105:0]       r_m;
  logic [105:0]       w_m_nxt;
  logic signed [12:0] r_e;
  logic signed [12:0] w_e_nxt;
  logic               r_st;
  logic               w_st_nxt;

  logic [53:0]        r_v;
  logic [12:0]        r_exp;
  logic               r_zero;
  logic               r_den;
  logic               r_ovf;

  logic [6:0]         w_lz;
  logic signed [12:0] w_em1;
  logic signed [12:0] w_sh;
  logic               w_zero;
  logic               w_den;
  logic               w_fin;

  function automatic logic [6:0] lzc105(
    input logic [104:0] m
  );
    logic [6:0] n;
    logic       found;
    n     = 7'd105;
    found = 1'b0;
    for (int i = 104; i >= 0; i--) begin
      if (!found && m[i]) begin
        n     = 7'(104 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Shift distance: leading zeros, clipped by STEP and the E=1 floor.
  always_comb begin
    w_lz  = lzc105(r_m[104:0]);
    w_em1 = r_e - 13'sd1;
    w_sh  = {6'd0, w_lz};
    if (STEP_S < w_sh) w_sh = STEP_S;
    if (w_em1 < w_sh) w_sh = w_em1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_m_nxt     = r_m;
    w_e_nxt     = r_e;
    w_st_nxt    = r_st;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_m_nxt     = sum_in;
          w_e_nxt     = exp_in;
          w_st_nxt    = sticky_in;
          w_state_nxt = ALIGN;
        end
      end
      ALIGN: begin
        w_state_nxt = DONE;
        if (r_m == '0) begin
          w_e_nxt = '0;
        end else if (r_m[105]) begin
          w_m_nxt  = r_m >> 1;
          w_st_nxt = r_st | r_m[0];
          w_e_nxt  = r_e + 13'sd1;
        end else if (r_m[104]) begin
          w_state_nxt = DONE;
        end else if (r_e <= 13'sd1) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_m_nxt = r_m << w_sh[6:0];
        w_e_nxt = r_e - w_sh;
        if (w_m_nxt[104] || (w_e_nxt == 13'sd1))
          w_state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_zero = ~|w_m_nxt & ~w_st_nxt;
  assign w_den  = ~w_m_nxt[104] & ~w_zero;
  assign w_fin  = (w_state_nxt == DONE) &&
                  (r_state != DONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m  <= '0;
      r_e  <= '0;
      r_st <= 1'b0;
    end else begin
      r_m  <= w_m_nxt;
      r_e  <= w_e_nxt;
      r_st <= w_st_nxt;
    end
  end

  // Result is captured once, on the transition into DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v    <= '0;
      r_exp  <= '0;
      r_zero <= 1'b0;
      r_den  <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (w_fin) begin
      r_v    <= {w_m_nxt[103:52], w_m_nxt[51],
                 (|w_m_nxt[50:0]) | w_st_nxt};
      r_exp  <= (w_den | w_zero) ? '0 : w_e_nxt;
      r_zero <= w_zero;
      r_den  <= w_den;
      r_ovf  <= (w_e_nxt >= EMAX_S) & ~w_zero;
    end
  end

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = (r_state == DONE);
  assign v_out        = r_v;
  assign exp_out      = r_exp;
  assign zero_out     = r_zero;
  assign denorm_out   = r_den;
  assign overflow_out = r_ovf;

endmodule

// File: tb/tb_fma_normalize_iter.sv
// Directed bench for fma_normalize_iter.
// Each task drives one scenario and checks inline.
module tb_fma_normalize_iter;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [105:0] sum_in;
  logic [12:0]  exp_in;
  logic         sticky_in;
  logic         out_valid;
  logic         out_ready;
  logic [53:0]  v_out;
  logic [12:0]  exp_out;
  logic         zero_out;
  logic         denorm_out;
  logic         overflow_out;

  int checks;
  int errors;

  fma_normalize_iter #(
    .STEP(16),
    .EMAX(2047)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sum_in      (sum_in),
    .exp_in      (exp_in),
    .sticky_in   (sticky_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .v_out       (v_out),
    .exp_out     (exp_out),
    .zero_out    (zero_out),
    .denorm_out  (denorm_out),
    .overflow_out(overflow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_op(
    input logic [105:0] s,
    input logic [12:0]  e,
    input logic         st
  );
    @(negedge clk);
    sum_in    = s;
    exp_in    = e;
    sticky_in = st;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got rdy=%b vld=%b want 1 0",
               in_ready, out_valid);
    end
    checks++;
    if ({v_out, exp_out, zero_out, denorm_out, overflow_out}
        !== '0) begin
      errors++;
      $display("FAIL reset_out got v=%h e=%h z=%b d=%b o=%b want 0",
               v_out, exp_out, zero_out, denorm_out, overflow_out);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_normalized();
    logic [105:0] s;
    int lat;
    s = '0;
    s[104] = 1'b1;
    s[103:52] = 52'hA5A5A5A5A5A5A;
    s[51] = 1'b1;
    s[0] = 1'b1;
    drive_op(s, 13'd1023, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL norm_lat got %0d want 2", lat);
    end
    checks++;
    if (v_out !== {52'hA5A5A5A5A5A5A, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL norm_v got %h want %h", v_out,
               {52'hA5A5A5A5A5A5A, 1'b1, 1'b1});
    end
    checks++;
    if (exp_out !== 13'd1023 ||
        {zero_out, denorm_out, overflow_out} !== 3'b000) begin
      errors++;
      $display("FAIL norm_exp got e=%0d zdo=%b want 1023 000",
               exp_out, {zero_out, denorm_out, overflow_out});
    end
    drain();
  endtask

  task automatic test_carry();
    logic [105:0] s;
    int lat;
    s = '0;
    s[105] = 1'b1;
    s[0] = 1'b1;
    drive_op(s, 13'd1023, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat !== 2 || exp_out !== 13'd1024) begin
      errors++;
      $display("FAIL carry_exp got lat=%0d e=%0d want 2 1024",
               lat, exp_out);
    end
    checks++;
    if (v_out !== 54'h1 || overflow_out !== 1'b0 ||
        denorm_out !== 1'b0) begin
      errors++;
      $display("FAIL carry_v got v=%h o=%b d=%b want 1 0 0",
               v_out, overflow_out, denorm_out);
    end
    drain();
    drive_op(s, 13'd2046, 1'b0);
    wait_valid(lat);
    checks++;
    if (overflow_out !== 1'b1 || exp_out !== 13'd2047) begin
      errors++;
      $display("FAIL carry_ovf got o=%b e=%0d want 1 2047",
               overflow_out, exp_out);
    end
    drain();
  endtask

  task automatic test_long_shift();
    int lat;
    drive_op(106'h1 << 20, 13'd1023, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL long_lat got %0d want 8", lat);
    end
    checks++;
    if (exp_out !== 13'd939 || v_out !== 54'h0 ||
        denorm_out !== 1'b0) begin
      errors++;
      $display("FAIL long_res got e=%0d v=%h d=%b want 939 0 0",
               exp_out, v_out, denorm_out);
    end
    drain();
  endtask

  task automatic test_denorm_clamp();
    int lat;
    drive_op(106'h1 << 80, 13'd10, 1'b0);
    wait_valid(lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL dnm_lat got %0d want 3", lat);
    end
    checks++;
    if (v_out !== (54'h1 << 39) || exp_out !== 13'd0 ||
        denorm_out !== 1'b1 || zero_out !== 1'b0) begin
      errors++;
      $display("FAIL dnm_res got v=%h e=%0d d=%b z=%b want %h 0 1 0",
               v_out, exp_out, denorm_out, zero_out,
               54'h1 << 39);
    end
    drain();
  endtask

  task automatic test_sticky_only();
    int lat;
    drive_op(106'h0, 13'd500, 1'b1);
    wait_valid(lat);
    checks++;
    if (v_out !== 54'h1 || exp_out !== 13'd0 ||
        denorm_out !== 1'b1 || zero_out !== 1'b0) begin
      errors++;
      $display("FAIL stk_res got v=%h e=%0d d=%b z=%b want 1 0 1 0",
               v_out, exp_out, denorm_out, zero_out);
    end
    drain();
  endtask

  task automatic test_zero_backpressure();
    int lat;
    logic [53:0] v0;
    @(negedge clk);
    out_ready = 1'b0;
    drive_op(106'h0, 13'd700, 1'b0);
    wait_valid(lat);
    checks++;
    if (zero_out !== 1'b1 || exp_out !== 13'd0 ||
        v_out !== 54'h0 || denorm_out !== 1'b0) begin
      errors++;
      $display("FAIL zero_res got z=%b e=%0d v=%h d=%b want 1 0 0 0",
               zero_out, exp_out, v_out, denorm_out);
    end
    v0 = v_out;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          zero_out !== 1'b1 || v_out !== v0) begin
        errors++;
        $display("FAIL bp_hold cyc=%0d got vld=%b rdy=%b z=%b want 1 0 1",
                 i, out_valid, in_ready, zero_out);
      end
    end
    drain();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rdy=%b vld=%b want 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_reset_during_shift();
    int seen;
    drive_op(106'h1, 13'd1000, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_shift got vld=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_noout got %0d valid cycles want 0", seen);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    in_valid  = 1'b0;
    sum_in    = '0;
    exp_in    = '0;
    sticky_in = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_normalized();
    test_carry();
    test_long_shift();
    test_denorm_clamp();
    test_sticky_only();
    test_zero_backpressure();
    test_reset_during_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
